// File: rtl/rtc_pkg.sv
// Shared constants and digit type for the hours/minutes/seconds real-time clock.
package rtc_pkg;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned SEC_MAX = 59;

  localparam int unsigned HR_W  = 5;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned DIV_W = 32;
  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

endpackage

// File: rtl/bin2bcd_2dig.sv
// Converts a binary value in 0-59 into two BCD digits (tens, ones).
module bin2bcd_2dig
  import rtc_pkg::*;
(
  input  logic [5:0] value,
  output bcd_t       tens,
  output bcd_t       ones
);

  always_comb begin
    tens = BCD_W'(value / 6'd10);
    ones = BCD_W'(value % 6'd10);
  end

endmodule

// File: rtl/rtc_hms_core.sv
// HH:MM:SS timekeeper with set mode and 12/24-hour BCD display.
// Optional alarm (ports alarm_load, alarm_clr, alarm) is built when RTC_ALARM_EN is defined.
module rtc_hms_core
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic mode_12h,
  input  logic set_time,
  input  logic inc_hr,
  input  logic inc_min,
  input  logic inc_sec,
`ifdef RTC_ALARM_EN
  input  logic alarm_load,
  input  logic alarm_clr,
  output logic alarm,
`endif
  output bcd_t h10,
  output bcd_t h1,
  output bcd_t m10,
  output bcd_t m1,
  output bcd_t s10,
  output bcd_t s1,
  output logic pm,
  output logic sec_tick
);

  logic [HR_W-1:0]  hr,  hr_nxt,  disp_hr;
  logic [MIN_W-1:0] min, min_nxt;
  logic [SEC_W-1:0] sec, sec_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             hr_wrap, min_wrap, sec_wrap;

  assign hr_wrap  = (hr  == HR_W'(HR_MAX));
  assign min_wrap = (min == MIN_W'(MIN_MAX));
  assign sec_wrap = (sec == SEC_W'(SEC_MAX));

  // Gated by reset so the CLK_DIV=1 case still shows no tick while held in reset.
  assign sec_tick = !reset && !set_time && (div_cnt == DIV_W'(CLK_DIV - 1));

  // Next time: independent field increments in set mode, carry chain when ticking.
  always_comb begin
    hr_nxt  = hr;
    min_nxt = min;
    sec_nxt = sec;
    if (set_time) begin
      if (inc_hr)  hr_nxt  = hr_wrap  ? '0 : hr  + HR_W'(1);
      if (inc_min) min_nxt = min_wrap ? '0 : min + MIN_W'(1);
      if (inc_sec) sec_nxt = sec_wrap ? '0 : sec + SEC_W'(1);
    end else if (sec_tick) begin
      sec_nxt = sec_wrap ? '0 : sec + SEC_W'(1);
      if (sec_wrap) begin
        min_nxt = min_wrap ? '0 : min + MIN_W'(1);
        if (min_wrap) hr_nxt = hr_wrap ? '0 : hr + HR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hr      <= '0;
      min     <= '0;
      sec     <= '0;
      div_cnt <= '0;
    end else begin
      hr      <= hr_nxt;
      min     <= min_nxt;
      sec     <= sec_nxt;
      div_cnt <= (set_time || sec_tick) ? '0 : div_cnt + DIV_W'(1);
    end
  end

`ifdef RTC_ALARM_EN
  logic [HR_W-1:0]  al_hr;
  logic [MIN_W-1:0] al_min;
  logic             alarm_hit;

  // Only a timekeeping advance can land on the alarm time; set-mode edits never do.
  assign alarm_hit = sec_tick && (hr_nxt == al_hr) && (min_nxt == al_min) && (sec_nxt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      al_hr  <= '0;
      al_min <= '0;
      alarm  <= 1'b0;
    end else begin
      if (alarm_load) begin
        al_hr  <= hr;
        al_min <= min;
      end
      if (alarm_hit)      alarm <= 1'b1;
      else if (alarm_clr) alarm <= 1'b0;
    end
  end
`endif

  always_comb begin
    disp_hr = hr;
    if (mode_12h) begin
      if (hr == '0)              disp_hr = HR_W'(12);
      else if (hr > HR_W'(12))   disp_hr = hr - HR_W'(12);
    end
  end

  assign pm = (hr >= HR_W'(12));

  bin2bcd_2dig u_hr_bcd  (.value({1'b0, disp_hr}), .tens(h10), .ones(h1));
  bin2bcd_2dig u_min_bcd (.value(min),             .tens(m10), .ones(m1));
  bin2bcd_2dig u_sec_bcd (.value(sec),             .tens(s10), .ones(s1));

endmodule

// File: tb/tb_rtc_hms_core.sv
// Directed self-checking bench for rtc_hms_core with CLK_DIV=4; alarm cases run when RTC_ALARM_EN is defined.
module tb_rtc_hms_core;

  localparam int unsigned CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode_12h = 1'b0;
  logic set_time = 1'b0;
  logic inc_hr = 1'b0;
  logic inc_min = 1'b0;
  logic inc_sec = 1'b0;
  logic [3:0] h10, h1, m10, m1, s10, s1;
  logic pm, sec_tick;
`ifdef RTC_ALARM_EN
  logic alarm_load = 1'b0;
  logic alarm_clr = 1'b0;
  logic alarm;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;
  int tick_base = 0;

  rtc_hms_core #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .mode_12h(mode_12h), .set_time(set_time),
    .inc_hr(inc_hr), .inc_min(inc_min), .inc_sec(inc_sec),
`ifdef RTC_ALARM_EN
    .alarm_load(alarm_load), .alarm_clr(alarm_clr), .alarm(alarm),
`endif
    .h10(h10), .h1(h1), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .pm(pm), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sec_tick) tick_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] disp();
    return {h10, h1, m10, m1, s10, s1};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Applies nh/nm/ns increment pulses, overlapping them in the same cycles.
  task automatic set_steps(input int nh, input int nm, input int ns);
    int n;
    n = (nh > nm) ? nh : nm;
    if (ns > n) n = ns;
    for (int i = 0; i < n; i++) begin
      inc_hr  = (i < nh);
      inc_min = (i < nm);
      inc_sec = (i < ns);
      cycles(1);
    end
    inc_hr = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
  endtask

  initial begin
    // Reset state in both display modes, and reset dominating set mode
    #2;
    check("rst_disp24", disp(), 24'h000000);
    check("rst_pm", pm, 1'b0);
    check("rst_tick", sec_tick, 1'b0);
    mode_12h = 1'b1; #1;
    check("rst_disp12", disp(), 24'h120000);
    mode_12h = 1'b0;
    set_time = 1'b1; inc_hr = 1'b1; inc_min = 1'b1; inc_sec = 1'b1;
    cycles(2);
    check("rst_dominates", disp(), 24'h000000);
    set_time = 1'b0; inc_hr = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;

    // Free running: tick every 4 cycles
    reset = 1'b0;
    tick_base = tick_cnt;
    cycles(3);
    check("first_tick", sec_tick, 1'b1);
    check("pre_adv", disp(), 24'h000000);
    cycles(1);
    check("post_tick", sec_tick, 1'b0);
    check("adv_1s", disp(), 24'h000001);
    cycles(8);
    check("run12_disp", disp(), 24'h000003);
    check("run12_ticks", tick_cnt - tick_base, 3);

    // Inc pulses ignored outside set mode
    inc_hr = 1'b1; inc_min = 1'b1; inc_sec = 1'b1;
    cycles(1);
    inc_hr = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
    check("inc_ignored", disp(), 24'h000003);

    // Set mode to 23:59:59, then simultaneous incs wrap with no carry
    set_time = 1'b1;
    set_steps(23, 59, 56);
    check("set_235959", disp(), 24'h235959);
    check("set_pm", pm, 1'b1);
    set_steps(1, 1, 1);
    check("inc_all_wrap", disp(), 24'h000000);
    check("set_no_tick", sec_tick, 1'b0);

    // Day rollover through timekeeping
    set_steps(23, 59, 59);
    set_time = 1'b0;
    cycles(3);
    check("roll_tick", sec_tick, 1'b1);
    check("roll_pre", disp(), 24'h235959);
    cycles(1);
    check("roll_disp", disp(), 24'h000000);
    check("roll_pm", pm, 1'b0);

    // 12/24-hour mapping
    set_time = 1'b1;
    set_steps(12, 0, 0);
    mode_12h = 1'b1; #1;
    check("h12_noon", disp(), 24'h120000);
    check("h12_noon_pm", pm, 1'b1);
    set_steps(1, 0, 0);
    mode_12h = 1'b0; #1;
    check("h24_13", disp(), 24'h130000);
    check("h24_13_pm", pm, 1'b1);
    mode_12h = 1'b1; #1;
    check("h12_13", disp(), 24'h010000);
    check("h12_13_pm", pm, 1'b1);
    set_steps(11, 0, 0);
    check("h12_midnight", disp(), 24'h120000);
    check("h12_midn_pm", pm, 1'b0);
    mode_12h = 1'b0; #1;
    check("h24_midnight", disp(), 24'h000000);

    // Asynchronous reset mid-second
    set_steps(11, 22, 33);
    check("set_112233", disp(), 24'h112233);
    set_time = 1'b0;
    cycles(2);
    @(negedge clk); #1;
    reset = 1'b1; #1;
    check("async_rst_disp", disp(), 24'h000000);
    check("async_rst_tick", sec_tick, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick_base = tick_cnt;
    cycles(3);
    check("rel_tick", sec_tick, 1'b1);
    cycles(1);
    check("rel_disp", disp(), 24'h000001);
    check("rel_ticks", tick_cnt - tick_base, 1);

`ifdef RTC_ALARM_EN
    // Alarm load at 00:01, trigger on timekeeping, hold, clear, set-over-clear
    set_time = 1'b1;
    set_steps(0, 1, 59);
    check("al_setmode_time", disp(), 24'h000100);
    check("al_idle", alarm, 1'b0);
    alarm_load = 1'b1; cycles(1); alarm_load = 1'b0;
    set_steps(0, 59, 50);
    check("al_pre_time", disp(), 24'h000050);
    set_time = 1'b0;
    cycles(39);
    check("al_before", disp(), 24'h000059);
    check("al_before_flag", alarm, 1'b0);
    cycles(1);
    check("al_hit_time", disp(), 24'h000100);
    check("al_hit", alarm, 1'b1);
    cycles(8);
    check("al_held", alarm, 1'b1);
    alarm_clr = 1'b1; cycles(1); alarm_clr = 1'b0;
    check("al_clr", alarm, 1'b0);
    set_time = 1'b1;
    set_steps(0, 59, 57);
    check("al_pre2", disp(), 24'h000059);
    set_time = 1'b0;
    cycles(3);
    alarm_clr = 1'b1; cycles(1); alarm_clr = 1'b0;
    check("al_set_wins", alarm, 1'b1);
    alarm_clr = 1'b1; cycles(1); alarm_clr = 1'b0;
    set_time = 1'b1;
    set_steps(0, 0, 59);
    set_steps(0, 0, 1);
    check("al_setmode_hit_time", disp(), 24'h000100);
    check("al_setmode_nohit", alarm, 1'b0);
    set_time = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rtc_hms_core.md
RTC_HMS_CORE -- requirements
Module: rtc_hms_core

Interface
REQ-001 Parameter CLK_DIV, default 100_000_000, is the number of clk cycles per second; legal range is 1 to 2^32-1.
REQ-002 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit, is an asynchronous active-high reset.
REQ-004 Port mode_12h, input, 1 bit, selects the display format: 1 for 12-hour, 0 for 24-hour.
REQ-005 Port set_time, input, 1 bit, is a level input that enables set mode and freezes timekeeping while high.
REQ-006 Ports inc_hr, inc_min and inc_sec, input, 1 bit each, are single-cycle increment pulses used in set mode.
REQ-007 Ports h10, h1, m10, m1, s10 and s1, output, 4 bits each, are the BCD display digits.
REQ-008 Port pm, output, 1 bit, is the PM indicator.
REQ-009 Port sec_tick, output, 1 bit, is a one-cycle pulse on each timekeeping advance.

Function
REQ-010 Internal state SHALL be binary hr (0-23, 5 bits), min (0-59, 6 bits), sec (0-59, 6 bits) and div_cnt (32 bits).
REQ-011 With set_time low, div_cnt SHALL count 0 to CLK_DIV-1 and then wrap to 0.
REQ-012 sec_tick SHALL be high combinationally in the cycle where div_cnt==CLK_DIV-1 and set_time==0, and the time SHALL advance one second on that edge.
REQ-013 With CLK_DIV=1, sec_tick SHALL be high every cycle while set_time is low.
REQ-014 Carries: sec 59->0 increments min; min 59->0 increments hr; 23:59:59 SHALL wrap to 00:00:00.
REQ-015 With set_time high, div_cnt SHALL be held at 0 and sec_tick SHALL be 0.
REQ-016 In set mode, inc_hr SHALL set hr to (hr+1) mod 24, inc_min SHALL set min to (min+1) mod 60 and inc_sec SHALL set sec to (sec+1) mod 60, with no carry between fields.
REQ-017 Simultaneous inc pulses SHALL all apply in the same cycle.
REQ-018 Inc pulses SHALL be ignored while set_time is low.
REQ-019 After set_time falls, the first sec_tick SHALL occur exactly CLK_DIV cycles later.
REQ-020 Digits and pm SHALL be combinational from the state registers, with zero latency.
REQ-021 In 24-hour mode, the displayed hour SHALL equal hr.
REQ-022 In 12-hour mode, the displayed hour SHALL map 0->12, 1..12->hr and 13..23->hr-12; the leading zero is not blanked, so h10=0 for hours 1-9.
REQ-023 pm SHALL equal (hr>=12) in both modes.
REQ-024 A change on mode_12h SHALL alter the display only, never the stored state.

Reset
REQ-025 Asserting reset SHALL immediately clear hr, min, sec, div_cnt and all alarm state to 0, regardless of clk.
REQ-026 During reset, outputs SHALL show 00:00:00 in 24-hour mode and 12:00:00 in 12-hour mode, with pm=0 and sec_tick=0 in both modes.
REQ-027 Reset SHALL dominate set_time and all inc pulses.

Configuration
REQ-028 With macro RTC_ALARM_EN defined, ports alarm_load (input, 1 bit), alarm_clr (input, 1 bit) and alarm (output, 1 bit) SHALL exist.
REQ-029 When enabled, alarm_load SHALL capture the current hr and min into alarm registers.
REQ-030 When enabled, alarm SHALL set on the edge where the time becomes al_hr:al_min:00 and SHALL hold until an alarm_clr pulse.
REQ-031 When enabled and clear and set coincide, set SHALL win.
REQ-032 Time entered via set mode SHALL NOT trigger the alarm.
REQ-033 Without RTC_ALARM_EN, the alarm ports and registers SHALL be absent and all other behaviour unchanged.

Structure
REQ-034 Package rtc_pkg SHALL hold the constants HR_MAX=23, MIN_MAX=59 and SEC_MAX=59, plus a bcd_t 4-bit typedef.
REQ-035 Sub-module bin2bcd_2dig SHALL convert a 0-59 binary value to two BCD digits and SHALL be instantiated three times.

Verification
REQ-036 CLK_DIV=4: release reset, run 12 cycles -> three sec_tick pulses, one every 4 cycles, and the display reads 00:00:03.
REQ-037 Set 23:59:59 in set mode, clear set_time, wait 4 cycles -> display 00:00:00, pm=0.
REQ-038 hr=13, toggle mode_12h 0->1 -> display changes 13->01 with pm=1 in both modes; hr=0 in 12-hour mode -> 12, pm=0.
REQ-039 set_time=1, pulse inc_hr, inc_min and inc_sec together from 23:59:59 -> 00:00:00 with no carry, and sec_tick stays 0.
REQ-040 Assert reset asynchronously mid-second at 11:22:33 -> outputs read 00:00:00 before the next clk edge, and the first tick comes 4 cycles after release.
REQ-041 With RTC_ALARM_EN defined: load alarm at 00:01, run to 00:01:00 -> alarm=1 and held; alarm_clr pulse -> alarm=0.
